// File: rtl/pulse_ramp_gen.sv
// pulse_ramp_gen: trapezoidal pulse sample generator feeding a DAC/source stage.
// Waveform: DELAY (once per start), then RISE, HIGH, FALL, LOW repeating.
// Durations count accepted samples, so back-pressure never distorts the shape.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   enable            level-sensitive run request
//   cfg_valid/ready   configuration handshake (ready only while idle)
//   cfg_v_low/high    plateau levels; cfg_rise/fall_step ramp steps (0 = jump)
//   cfg_td/th/tl      delay, high and low plateau lengths in samples
//   cfg_err           one-cycle pulse when a config with v_high < v_low is offered
//   out_valid/ready   sample stream handshake; out_data sample code
//   running           generator is not idle
// Optional build macro PULSE_RAMP_GEN_BURST_EN adds cfg_burst (period count,
// 0 = unlimited) and a one-cycle done pulse when the burst completes.
module pulse_ramp_gen #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] cfg_v_low,
  input  logic [WIDTH-1:0] cfg_v_high,
  input  logic [WIDTH-1:0] cfg_rise_step,
  input  logic [WIDTH-1:0] cfg_fall_step,
  input  logic [CNT_W-1:0] cfg_td,
  input  logic [CNT_W-1:0] cfg_th,
  input  logic [CNT_W-1:0] cfg_tl,
  output logic             cfg_err,
`ifdef PULSE_RAMP_GEN_BURST_EN
  input  logic [CNT_W-1:0] cfg_burst,
  output logic             done,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             running
);

  typedef enum logic [2:0] {
    S_IDLE, S_DELAY, S_RISE, S_HIGH, S_FALL, S_LOW
  } state_t;

  state_t           r_state, w_state_n;
  logic [CNT_W-1:0] r_cnt, w_cnt_n;
  logic [WIDTH-1:0] r_data, w_data_n;
  logic             r_valid, w_valid_n;
  logic             r_cfg_err;

  logic [WIDTH-1:0] r_v_low, r_v_high, r_rise, r_fall;
  logic [CNT_W-1:0] r_td, r_th, r_tl;

`ifdef PULSE_RAMP_GEN_BURST_EN
  logic [CNT_W-1:0] r_burst, r_period, w_period_n, w_period_inc;
  logic             r_done, w_done_n, r_hold, w_hold_n, w_period_end;
`endif

  logic             w_cfg_bad, w_cfg_acc, w_xfer;
  logic [WIDTH-1:0] w_rise_base, w_rise_val, w_fall_val;
  logic [WIDTH:0]   w_sum, w_diff;

  assign w_cfg_bad = cfg_v_high < cfg_v_low;
  assign w_cfg_acc = cfg_valid & cfg_ready & ~w_cfg_bad;
  assign w_xfer    = r_valid & out_ready;

  // Ramps are computed one bit wider and clamped to the plateau levels.
  assign w_rise_base = (r_state == S_RISE) ? r_data : r_v_low;
  assign w_sum       = {1'b0, w_rise_base} + {1'b0, r_rise};
  assign w_rise_val  = ((r_rise == '0) || (w_sum >= {1'b0, r_v_high}))
                       ? r_v_high : w_sum[WIDTH-1:0];
  assign w_diff      = {1'b0, r_data} - {1'b0, r_fall};
  assign w_fall_val  = ((r_fall == '0) || w_diff[WIDTH] ||
                        (w_diff[WIDTH-1:0] <= r_v_low))
                       ? r_v_low : w_diff[WIDTH-1:0];

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_data_n  = r_data;
    w_valid_n = r_valid;
`ifdef PULSE_RAMP_GEN_BURST_EN
    w_period_n   = r_period;
    w_period_inc = r_period + CNT_W'(1);
    w_done_n     = 1'b0;
    w_hold_n     = r_hold;
    w_period_end = 1'b0;
    if (!enable) w_hold_n = 1'b0;
`endif
    if (r_state == S_IDLE) begin
      w_valid_n = 1'b0;
      // A configuration offer takes the cycle; the start follows once it is gone.
`ifdef PULSE_RAMP_GEN_BURST_EN
      if (enable && !cfg_valid && !r_hold) begin
        w_period_n = '0;
`else
      if (enable && !cfg_valid) begin
`endif
        w_valid_n = 1'b1;
        if (r_td != '0) begin
          w_state_n = S_DELAY;
          w_cnt_n   = r_td;
          w_data_n  = r_v_low;
        end else begin
          w_state_n = S_RISE;
          w_data_n  = w_rise_val;
        end
      end
    end else if (!enable) begin
      w_state_n = S_IDLE;
      w_valid_n = 1'b0;
    end else if (w_xfer) begin
      unique case (r_state)
        S_DELAY: begin
          if (r_cnt > CNT_W'(1)) begin
            w_cnt_n = r_cnt - CNT_W'(1);
          end else begin
            w_state_n = S_RISE;
            w_data_n  = w_rise_val;
          end
        end
        S_RISE: begin
          if (r_data == r_v_high) begin
            if (r_th != '0) begin
              w_state_n = S_HIGH;
              w_cnt_n   = r_th;
              w_data_n  = r_v_high;
            end else begin
              w_state_n = S_FALL;
              w_data_n  = w_fall_val;
            end
          end else begin
            w_data_n = w_rise_val;
          end
        end
        S_HIGH: begin
          if (r_cnt > CNT_W'(1)) begin
            w_cnt_n = r_cnt - CNT_W'(1);
          end else begin
            w_state_n = S_FALL;
            w_data_n  = w_fall_val;
          end
        end
        S_FALL: begin
          if (r_data == r_v_low) begin
            if (r_tl != '0) begin
              w_state_n = S_LOW;
              w_cnt_n   = r_tl;
              w_data_n  = r_v_low;
            end else begin
              w_state_n = S_RISE;
              w_data_n  = w_rise_val;
`ifdef PULSE_RAMP_GEN_BURST_EN
              w_period_end = 1'b1;
`endif
            end
          end else begin
            w_data_n = w_fall_val;
          end
        end
        S_LOW: begin
          if (r_cnt > CNT_W'(1)) begin
            w_cnt_n = r_cnt - CNT_W'(1);
          end else begin
            w_state_n = S_RISE;
            w_data_n  = w_rise_val;
`ifdef PULSE_RAMP_GEN_BURST_EN
            w_period_end = 1'b1;
`endif
          end
        end
        default: w_state_n = S_IDLE;
      endcase
`ifdef PULSE_RAMP_GEN_BURST_EN
      // Burst end overrides the wrap to RISE; hold off restart until enable drops.
      if (w_period_end) begin
        if ((r_burst != '0) && (w_period_inc == r_burst)) begin
          w_state_n = S_IDLE;
          w_valid_n = 1'b0;
          w_data_n  = r_data;
          w_done_n  = 1'b1;
          w_hold_n  = 1'b1;
        end else begin
          w_period_n = w_period_inc;
        end
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_cfg_err <= 1'b0;
      r_v_low   <= '0;
      r_v_high  <= '0;
      r_rise    <= '0;
      r_fall    <= '0;
      r_td      <= '0;
      r_th      <= '0;
      r_tl      <= '0;
`ifdef PULSE_RAMP_GEN_BURST_EN
      r_burst   <= '0;
      r_period  <= '0;
      r_done    <= 1'b0;
      r_hold    <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_n;
      r_cnt     <= w_cnt_n;
      r_data    <= w_data_n;
      r_valid   <= w_valid_n;
      r_cfg_err <= cfg_valid & cfg_ready & w_cfg_bad;
      if (w_cfg_acc) begin
        r_v_low  <= cfg_v_low;
        r_v_high <= cfg_v_high;
        r_rise   <= cfg_rise_step;
        r_fall   <= cfg_fall_step;
        r_td     <= cfg_td;
        r_th     <= cfg_th;
        r_tl     <= cfg_tl;
`ifdef PULSE_RAMP_GEN_BURST_EN
        r_burst  <= cfg_burst;
`endif
      end
`ifdef PULSE_RAMP_GEN_BURST_EN
      r_period <= w_period_n;
      r_done   <= w_done_n;
      r_hold   <= w_hold_n;
`endif
    end
  end

  assign cfg_ready = (r_state == S_IDLE);
  assign cfg_err   = r_cfg_err;
  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign running   = (r_state != S_IDLE);
`ifdef PULSE_RAMP_GEN_BURST_EN
  assign done      = r_done;
`endif

endmodule
